// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the hex-reporting UART path: ASCII constants,
// FSM state encoding, default bit timing and the nibble-to-ASCII helper.
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    localparam int DEF_CLK_FREQ     = 50_000_000;
    localparam int DEF_BAUD         = 115_200;
    localparam int DEF_CLKS_PER_BIT = DEF_CLK_FREQ / DEF_BAUD;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        NEXT
    } uart_state_t;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_0 + {4'd0, n};
        end
        return ASCII_A + ({4'd0, n} - 8'd10);
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
// 8N1 byte serializer, LSB first, each bit CLKS_PER_BIT cycles.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load, data byte request; accepted whenever ready is high
//   ready      high in IDLE and in the final cycle of the stop bit, so a
//              new byte loaded then starts with no idle gap
//   tx         registered serial output, idle high
//
// state | meaning
// IDLE  | line idle, waiting for load
// START | driving start bit
// DATA  | driving data bits 0-7 (bit counter)
// STOP  | driving stop bit
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign tx      = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (load) begin
                        state_d = START;
                        bit_d   = '0;
                        shift_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_hex_reporter.sv
// uart_hex_reporter
// Sends an 8-bit value as the ASCII line "<hi hex><lo hex>\r\n" over UART.
// Ports:
//   CLOCK_50  system clock
//   Reset     synchronous active-high reset
//   value     byte to report, sampled when send is high
//   send      one-cycle request strobe
//   tx        UART serial output (8N1, idle high)
//   busy      high while a message is on the line
//   done      one-cycle pulse after the LF stop bit
//   pending   a queued request is waiting
//
// state | meaning
// IDLE  | no message in flight
// START | a character frame is being serialized
// NEXT  | one-cycle gap, loads the next character
module uart_hex_reporter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int BAUD         = DEF_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [7:0] value,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       pending
);

    uart_state_t state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  msg_q, msg_d;
    logic [7:0]  pend_val_q, pend_val_d;
    logic        pend_q, pend_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        load;
    logic [7:0]  load_byte;
    logic [7:0]  next_msg;
    logic        ser_ready;

    function automatic logic [7:0] char_at(input logic [7:0] msg, input logic [1:0] idx);
        case (idx)
            2'd0:    return hex_char(msg[7:4]);
            2'd1:    return hex_char(msg[3:0]);
            2'd2:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (CLOCK_50),
        .rst   (Reset),
        .load  (load),
        .data  (load_byte),
        .ready (ser_ready),
        .tx    (tx)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign pending = pend_q;

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            msg_q      <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            msg_q      <= msg_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        msg_d      = msg_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load       = 1'b0;
        load_byte  = char_at(msg_q, idx_q);
        // A fresh send always beats an older queued value.
        next_msg   = send ? value : pend_val_q;

        if ((state_q != IDLE) && send) begin
            pend_d     = 1'b1;
            pend_val_d = value;
        end

        case (state_q)
            IDLE: begin
                if (send || pend_q) begin
                    msg_d     = next_msg;
                    idx_d     = '0;
                    pend_d    = 1'b0;
                    load      = 1'b1;
                    load_byte = hex_char(next_msg[7:4]);
                    state_d   = START;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (ser_ready) begin
                    if (idx_q != 2'd3) begin
                        state_d = NEXT;
                        idx_d   = idx_q + 1'b1;
                    end else begin
                        done_d = 1'b1;
                        // Queued request chains straight into its start bit.
                        if (send || pend_q) begin
                            msg_d     = next_msg;
                            idx_d     = '0;
                            pend_d    = 1'b0;
                            load      = 1'b1;
                            load_byte = hex_char(next_msg[7:4]);
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            NEXT: begin
                load    = 1'b1;
                state_d = START;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_hex_reporter.sv
module tb_uart_hex_reporter;

    localparam int N       = 8;            // 1 MHz / 125 kbaud
    localparam int MSG_CYC = 40 * N + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] value = 8'h00;
    logic       tx, busy, done, pending;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         epoch = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];

    uart_hex_reporter #(
        .CLK_FREQ(1_000_000),
        .BAUD    (125_000)
    ) dut (
        .CLOCK_50(clk),
        .Reset   (rst),
        .value   (value),
        .send    (send),
        .tx      (tx),
        .busy    (busy),
        .done    (done),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_msg(input logic [7:0] b0, input logic [7:0] b1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic send_now(input logic [7:0] v);
        value = v;
        send  = 1'b1;
        @(negedge clk);
        send  = 1'b0;
    endtask

    task automatic pulse_send(input logic [7:0] v);
        @(negedge clk);
        send_now(v);
    endtask

    task automatic wait_done(output int t);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (done !== 1'b1 && t < 4 * MSG_CYC);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles", t);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && done === 1'b1) done_cnt++;
    end

    // UART receiver: samples mid-bit and pops the expected byte per frame.
    initial begin : monitor
        logic [7:0] b;
        logic [7:0] e;
        logic       st, sp;
        int         ep;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                ep = epoch;
                repeat (N / 2) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (N) @(negedge clk);
                    b[i] = tx;
                end
                repeat (N) @(negedge clk);
                sp = tx;
                if (ep == epoch) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame: unexpected byte %02h", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (st !== 1'b0 || sp !== 1'b1 || b !== e) begin
                            errors++;
                            $display("FAIL frame: got byte %02h start %b stop %b, expected byte %02h start 0 stop 1",
                                     b, st, sp, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        int t;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pending", pending, 0);

        // 0x3A -> "3A\r\n"
        push_msg(8'h33, 8'h41);
        pulse_send(8'h3A);
        check("t1_tx_start", tx, 0);
        check("t1_busy_start", busy, 1);
        wait_done(t);
        check("t1_done_latency", t, MSG_CYC);
        check("t1_busy_at_done", busy, 0);
        @(negedge clk);
        check("t1_done_width", done, 0);

        // 0x00, then 0xFF sent in the done cycle
        push_msg(8'h30, 8'h30);
        pulse_send(8'h00);
        wait_done(t);
        check("t2_done_latency_00", t, MSG_CYC);
        push_msg(8'h46, 8'h46);
        send_now(8'hFF);
        check("t2_tx_start_ff", tx, 0);
        check("t2_pending_ff", pending, 0);
        wait_done(t);
        check("t2_done_latency_ff", t, MSG_CYC);

        // queued request chains with no idle gap
        push_msg(8'h31, 8'h32);
        push_msg(8'h30, 8'h37);
        pulse_send(8'h12);
        repeat (50) @(negedge clk);
        pulse_send(8'h07);
        check("t3_pending_set", pending, 1);
        wait_done(t);
        check("t3_busy_at_done", busy, 1);
        check("t3_tx_chain_start", tx, 0);
        check("t3_pending_clear", pending, 0);
        wait_done(t);
        check("t3_chain_latency", t, MSG_CYC);
        @(negedge clk);
        check("t3_busy_end", busy, 0);

        // last request wins
        push_msg(8'h35, 8'h35);
        push_msg(8'h32, 8'h32);
        pulse_send(8'h55);
        repeat (20) @(negedge clk);
        pulse_send(8'h11);
        repeat (5) @(negedge clk);
        pulse_send(8'h22);
        check("t4_pending_set", pending, 1);
        wait_done(t);
        wait_done(t);
        check("t4_chain_latency", t, MSG_CYC);

        // reset in DATA of the second character
        exp_q.push_back(8'h43);
        pulse_send(8'hC3);
        repeat (5) @(negedge clk);
        pulse_send(8'h99);
        check("t5_pending_set", pending, 1);
        repeat (12 * N) @(negedge clk);
        rst = 1'b1;
        epoch++;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_pending", pending, 0);
        repeat (12 * N) @(negedge clk);
        check("t5_quiet_tx", tx, 1);
        check("t5_quiet_busy", busy, 0);
        push_msg(8'h35, 8'h43);
        pulse_send(8'h5C);
        wait_done(t);
        check("t5_done_latency_5c", t, MSG_CYC);

        // send coincident with reset is ignored
        @(negedge clk);
        rst   = 1'b1;
        send  = 1'b1;
        value = 8'hAB;
        @(negedge clk);
        rst  = 1'b0;
        send = 1'b0;
        check("t6_tx", tx, 1);
        check("t6_busy", busy, 0);
        check("t6_pending", pending, 0);
        repeat (3 * N) @(negedge clk);
        check("t6_tx_later", tx, 1);
        check("t6_busy_later", busy, 0);

        repeat (15 * N) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        check("done_count", done_cnt, 8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
